uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one uart_tx instance among NUM_REQ byte requesters.
- Accepts a byte from the granted requester over a valid/ready handshake and latches the line configuration.
- Pulses tx_start, then times the full serial frame internally, because uart_tx has no busy/done output.
- Sits between the host-side producers and uart_tx; drives every uart_tx input except clk and the reset.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_sched_if.sv | 17 +
 rtl/uart_rr_arb.sv | 34 +++
 rtl/uart_tx_sched.sv | 133 +++++++++++++
 tb/tb_uart_tx_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame arithmetic for the uart_tx scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } sched_state_e;

  localparam int START_BITS     = 1;
  localparam int MIN_DATA_BITS  = 5;
  localparam int MAX_FRAME_BITS = 12;

  // Serial bits in one frame: start + data + optional parity + stop(s).
  function automatic int frame_bits(input logic [1:0] data_bit_len,
                                    input logic       parity_en,
                                    input logic       num_of_stop_bits);
    return START_BITS + MIN_DATA_BITS + int'(data_bit_len) + int'(parity_en)
           + 1 + int'(num_of_stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side byte handshake bundle for the uart_tx scheduler.
//
// Handshake: a requester raises req_valid[i] with req_data[8i+7:8i] and holds
// both stable until it sees req_ready[i]. A byte transfers on the clock edge
// where req_valid[i] and req_ready[i] are both high. At most one req_ready bit
// is high in any cycle. Dropping req_valid before ready is legal and simply
// withdraws the request.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: first valid index after 'last', wrapping.
module uart_rr_arb #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan last+1, last+2, ... and keep the first valid index as the winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int j = 1; j <= NUM_REQ; j++) begin
      idx = IDX_W'((int'(last) + j) % NUM_REQ);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte requesters.
// uart_tx has no busy/done, so the frame length is timed here from the
// configuration latched at grant.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int CLKS_PER_BIT = 1,
  parameter  int GAP_BITS     = 1,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_sched_if.slave     req,
  input  logic               cfg_parity_en,
  input  logic               cfg_even_odd_parity,
  input  logic [1:0]         cfg_data_bit_len,
  input  logic               cfg_num_of_stop_bits,
  output logic               tx_start,
  output logic [7:0]         data_in,
  output logic               parity_en,
  output logic               even_odd_parity,
  output logic [1:0]         data_bit_len,
  output logic               num_of_stop_bits,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_id,
  output sched_state_e       state_dbg
);

  localparam int TW      = $clog2(MAX_FRAME_BITS * CLKS_PER_BIT);
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam logic [TW-1:0] GAP_LOAD = (GAP_CYC > 0) ? TW'(GAP_CYC - 1) : '0;

  sched_state_e       state, state_nx;
  logic [TW-1:0]      timer, timer_nx;
  logic [IDX_W-1:0]   last;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [NUM_REQ-1:0] ready;
  logic               load;
  logic [TW-1:0]      frame_load;

  uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid     (req.req_valid),
    .last      (last),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  // Frame timer reload uses the latched line config, never the live cfg_* inputs.
  assign frame_load = TW'(frame_bits(data_bit_len, parity_en, num_of_stop_bits)
                          * CLKS_PER_BIT - 1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, timer update and accept strobe.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    ready    = '0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          ready    = arb_grant;
          load     = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        timer_nx = frame_load;
        state_nx = SEND;
      end
      SEND: begin
        if (timer == '0) begin
          if (GAP_CYC == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx = GAP;
            timer_nx = GAP_LOAD;
          end
        end else begin
          timer_nx = timer - TW'(1);
        end
      end
      GAP: begin
        if (timer == '0) state_nx = IDLE;
        else             timer_nx = timer - TW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame/gap down-counter.
  always_ff @(posedge clk) begin
    if (rst) timer <= '0;
    else     timer <= timer_nx;
  end

  // Latch the granted byte, line config and round-robin pointer at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_in          <= '0;
      parity_en        <= 1'b0;
      even_odd_parity  <= 1'b0;
      data_bit_len     <= 2'b11;
      num_of_stop_bits <= 1'b0;
      grant_id         <= '0;
      last             <= IDX_W'(NUM_REQ - 1);
    end else if (load) begin
      data_in          <= req.req_data[8*arb_idx +: 8];
      parity_en        <= cfg_parity_en;
      even_odd_parity  <= cfg_even_odd_parity;
      data_bit_len     <= cfg_data_bit_len;
      num_of_stop_bits <= cfg_num_of_stop_bits;
      grant_id         <= arb_idx;
      last             <= arb_idx;
    end
  end

  // No accept may be signalled while reset is being applied.
  assign req.req_ready = ready & {NUM_REQ{~rst}};
  assign tx_start      = (state == START);
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: three instances with different bit timing / gap
// settings, each checked every cycle against a schedule-level model.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic       rst_i [3];
  logic [3:0] vld   [3];
  logic [31:0] dat  [3];
  logic       pe    [3];
  logic       eo    [3];
  logic       stp   [3];
  logic [1:0] dbl   [3];
  logic [3:0] rdy   [3];
  logic [3:0] acc   [3];

  logic       o_start [3];
  logic [7:0] o_data  [3];
  logic       o_pe    [3];
  logic       o_eo    [3];
  logic       o_stp   [3];
  logic [1:0] o_dbl   [3];
  logic       o_busy  [3];
  logic [1:0] o_gid   [3];
  uart_pkg::sched_state_e o_st [3];

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT instances ----------------
  // 0: CLKS_PER_BIT=1, GAP_BITS=1   1: 16, 1   2: 2, 0
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CPB   = (g == 1) ? 16 : ((g == 2) ? 2 : 1);
    localparam int GAP_B = (g == 2) ? 0 : 1;
    uart_tx_sched_if #(.NUM_REQ(4)) bus ();
    assign bus.req_valid = vld[g];
    assign bus.req_data  = dat[g];
    assign rdy[g]        = bus.req_ready;
    uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(CPB), .GAP_BITS(GAP_B)) u_dut (
      .clk                  (clk),
      .rst                  (rst_i[g]),
      .req                  (bus),
      .cfg_parity_en        (pe[g]),
      .cfg_even_odd_parity  (eo[g]),
      .cfg_data_bit_len     (dbl[g]),
      .cfg_num_of_stop_bits (stp[g]),
      .tx_start             (o_start[g]),
      .data_in              (o_data[g]),
      .parity_en            (o_pe[g]),
      .even_odd_parity      (o_eo[g]),
      .data_bit_len         (o_dbl[g]),
      .num_of_stop_bits     (o_stp[g]),
      .busy                 (o_busy[g]),
      .grant_id             (o_gid[g]),
      .state_dbg            (o_st[g])
    );
  end

  // ---------------- scoreboard helpers ----------------
  function automatic void chk(input string name, input int n,
                              input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, n, cyc, act, exp);
    end
  endfunction

  // Schedule-level model: a grant at cycle c means tx_start at c+1 and the
  // scheduler idle again at c+2 + frame_bits*cpb + gap*cpb.
  task automatic model(input int n, input int cpb, input int gap);
    int         c = 0;
    int         idle_at = 0;
    int         start_at = -1;
    int         last = 3;
    int         k;
    int         fb;
    bit         armed = 1'b0;
    logic [3:0] exp_rdy;
    logic [7:0] m_data = 8'h00;
    logic       m_pe = 1'b0, m_eo = 1'b0, m_stp = 1'b0;
    logic [1:0] m_dbl = 2'b11;
    int         m_gid = 0;
    logic [7:0] exp_q[$];
    forever begin
      @(negedge clk);
      c++;
      acc[n] = rdy[n] & vld[n];
      exp_rdy = 4'b0000;
      k = -1;
      if (!rst_i[n] && c >= idle_at) begin
        for (int j = 1; j <= 4; j++)
          if (k < 0 && vld[n][(last + j) % 4]) k = (last + j) % 4;
        if (k >= 0) exp_rdy[k] = 1'b1;
      end
      if (armed) begin
        chk("req_ready", n, rdy[n], exp_rdy);
        chk("busy", n, o_busy[n], c < idle_at);
        chk("state_idle", n, o_st[n] == uart_pkg::IDLE, !(c < idle_at));
        chk("tx_start", n, o_start[n], c == start_at);
        chk("data_in", n, o_data[n], m_data);
        chk("parity_en", n, o_pe[n], m_pe);
        chk("even_odd", n, o_eo[n], m_eo);
        chk("data_bit_len", n, o_dbl[n], m_dbl);
        chk("stop_bits", n, o_stp[n], m_stp);
        chk("grant_id", n, o_gid[n], m_gid);
        if (c == start_at && exp_q.size() > 0)
          chk("start_byte", n, o_data[n], exp_q.pop_front());
      end
      if (rst_i[n]) begin
        armed = 1'b1;
        idle_at = c + 1; start_at = -1; last = 3;
        m_data = 8'h00; m_pe = 1'b0; m_eo = 1'b0; m_stp = 1'b0;
        m_dbl = 2'b11; m_gid = 0;
        exp_q.delete();
      end else if (k >= 0) begin
        m_data = dat[n][8*k +: 8];
        m_pe = pe[n]; m_eo = eo[n]; m_stp = stp[n]; m_dbl = dbl[n];
        m_gid = k; last = k;
        exp_q.push_back(m_data);
        fb = 1 + 5 + int'(m_dbl) + int'(m_pe) + 1 + int'(m_stp);
        start_at = c + 1;
        idle_at = c + 2 + fb * cpb + gap * cpb;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_i[n] = 1'b1;
    tick(1);
    rst_i[n] = 1'b0;
  endtask

  task automatic set_cfg(input int n, input logic p, input logic e,
                         input logic [1:0] d, input logic s);
    pe[n] = p; eo[n] = e; dbl[n] = d; stp[n] = s;
  endtask

  // Wait (bounded) for a ready pulse; returns its index and cycle, ends at posedge+1.
  task automatic wait_ready(input int n, output int k, output int at);
    k = -1;
    at = 0;
    for (int t = 0; t < 400 && k < 0; t++) begin
      @(negedge clk);
      if (rdy[n] != 4'b0000) begin
        at = cyc;
        for (int i = 3; i >= 0; i--) if (rdy[n][i]) k = i;
      end
    end
    chk("ready_seen", n, k >= 0, 1);
    tick(1);
  endtask

  // Count busy cycles (bounded) from the next negedge onwards.
  task automatic count_busy(input int n, output int cnt);
    cnt = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (!o_busy[n]) break;
      cnt++;
    end
    tick(1);
  endtask

  task automatic rand_phase(input int n, input int ncyc, input int rst_odds);
    for (int t = 0; t < ncyc; t++) begin
      rst_i[n] = ($urandom_range(0, rst_odds - 1) == 0);
      for (int i = 0; i < 4; i++) begin
        if (vld[n][i] && acc[n][i]) begin
          vld[n][i] = 1'($urandom_range(0, 1));
          dat[n][8*i +: 8] = 8'($urandom);
        end else if (vld[n][i]) begin
          if ($urandom_range(0, 31) == 0) vld[n][i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          vld[n][i] = 1'b1;
          dat[n][8*i +: 8] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 3) == 0)
        set_cfg(n, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      tick(1);
    end
    rst_i[n] = 1'b0;
    vld[n] = 4'b0000;
    tick(2);
  endtask

  // ---------------- directed + random sequences ----------------
  task automatic seq0();
    int k, at, cnt;
    tick(1);
    do_reset(0);
    @(negedge clk);
    chk("rst_busy", 0, o_busy[0], 0);
    chk("rst_start", 0, o_start[0], 0);
    chk("rst_data", 0, o_data[0], 8'h00);
    chk("rst_dbl", 0, o_dbl[0], 2'b11);
    chk("rst_gid", 0, o_gid[0], 0);
    tick(1);
    // single request, 8N1
    set_cfg(0, 1'b0, 1'b0, 2'b11, 1'b0);
    dat[0] = 32'h00A5_0000;
    vld[0] = 4'b0100;
    wait_ready(0, k, at);
    vld[0] = 4'b0000;
    chk("single_gnt", 0, k, 2);
    @(negedge clk);
    chk("single_start", 0, o_start[0], 1);
    chk("single_data", 0, o_data[0], 8'hA5);
    tick(1);
    count_busy(0, cnt);
    chk("single_busy_len", 0, cnt + 1, 1 + 10 + 1);
    // contention: all four held valid
    do_reset(0);
    dat[0] = 32'h1312_1110;
    vld[0] = 4'hF;
    for (int f = 0; f < 5; f++) begin
      wait_ready(0, k, at);
      chk("rr_order", 0, k, f % 4);
    end
    vld[0] = 4'b0000;
    // config change during SEND
    do_reset(0);
    set_cfg(0, 1'b0, 1'b0, 2'b11, 1'b0);
    dat[0] = 32'h0000_003C;
    vld[0] = 4'b0001;
    wait_ready(0, k, at);
    vld[0] = 4'b0000;
    tick(3);
    dbl[0] = 2'b00;
    @(negedge clk);
    chk("cfg_hold_dbl", 0, o_dbl[0], 2'b11);
    tick(1);
    count_busy(0, cnt);
    dat[0] = 32'h0000_5A00;
    vld[0] = 4'b0010;
    wait_ready(0, k, at);
    vld[0] = 4'b0000;
    @(negedge clk);
    chk("cfg_new_dbl", 0, o_dbl[0], 2'b00);
    chk("cfg_new_data", 0, o_data[0], 8'h5A);
    tick(1);
    count_busy(0, cnt);
    chk("cfg_5n1_len", 0, cnt, 7 + 1);
    // reset during SEND; requester 0 must then beat requester 3
    do_reset(0);
    dat[0] = 32'h0077_0000;
    vld[0] = 4'b0100;
    wait_ready(0, k, at);
    vld[0] = 4'b0000;
    chk("pre_rst_gnt", 0, k, 2);
    tick(3);
    dat[0] = 32'h0800_0001;
    vld[0] = 4'b1001;
    rst_i[0] = 1'b1;
    tick(1);
    rst_i[0] = 1'b0;
    @(negedge clk);
    chk("midrst_start", 0, o_start[0], 0);
    chk("midrst_busy", 0, o_busy[0], 0);
    chk("midrst_data", 0, o_data[0], 8'h00);
    chk("midrst_ready", 0, rdy[0], 4'b0001);
    tick(1);
    vld[0][0] = 1'b0;
    wait_ready(0, k, at);
    vld[0] = 4'b0000;
    chk("midrst_next", 0, k, 3);
    rand_phase(0, 3000, 400);
  endtask

  task automatic seq1();
    int k, at, cnt;
    tick(1);
    do_reset(1);
    set_cfg(1, 1'b1, 1'b0, 2'b00, 1'b1);
    dat[1] = 32'h0000_00C3;
    vld[1] = 4'b0001;
    wait_ready(1, k, at);
    vld[1] = 4'b0000;
    chk("long_gnt", 1, k, 0);
    @(negedge clk);
    chk("long_start", 1, o_start[1], 1);
    chk("long_pe", 1, o_pe[1], 1);
    tick(1);
    count_busy(1, cnt);
    chk("long_frame_len", 1, cnt, 9 * 16 + 16);
    rand_phase(1, 5000, 2000);
  endtask

  task automatic seq2();
    int k, a1, a2;
    tick(1);
    do_reset(2);
    set_cfg(2, 1'b0, 1'b0, 2'b11, 1'b0);
    dat[2] = 32'h0000_9900;
    vld[2] = 4'b0010;
    wait_ready(2, k, a1);
    chk("gap0_gnt_a", 2, k, 1);
    wait_ready(2, k, a2);
    chk("gap0_gnt_b", 2, k, 1);
    // START, then SEND for 10 bits * 2 clocks, then the IDLE accept cycle
    chk("gap0_period", 2, a2 - a1, 10 * 2 + 2);
    vld[2] = 4'b0000;
    tick(30);
    rand_phase(2, 3000, 600);
  endtask

  // ---------------- main / report ----------------
  initial begin
    for (int n = 0; n < 3; n++) begin
      rst_i[n] = 1'b1;
      vld[n] = 4'b0000;
      dat[n] = 32'h0;
      acc[n] = 4'b0000;
      set_cfg(n, 1'b0, 1'b0, 2'b11, 1'b0);
    end
    fork
      model(0, 1, 1);
      model(1, 16, 1);
      model(2, 2, 0);
    join_none
    fork
      seq0();
      seq1();
      seq2();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
